// File: rtl/seg7_scan_4d_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment display driver.
// Default timing is 1 ms per digit slot at 100 MHz.
package seg7_scan_4d_pkg;

   localparam int PRESCALE_DEF  = 100000;
   localparam int BLANK_CYC_DEF = 1000;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   typedef enum logic [1:0] {
      DIG_0 = 2'd0,
      DIG_1 = 2'd1,
      DIG_2 = 2'd2,
      DIG_3 = 2'd3
   } digit_idx_e;

   // Active-low anode pattern for one digit; the upper four board digits stay dark.
   function automatic logic [7:0] an_select(input logic [1:0] idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return {4'hF, ~onehot};
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment cathodes, seg[6:0] = {g,f,e,d,c,b,a}.
// Codes A-F are not valid BCD and render as a dash.
module seg7_decoder
   import seg7_scan_4d_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_4d.sv
// Time-multiplexed driver for the Nexys4 DDR common-anode display: frame-coherent
// snapshot of the BCD bus, leading-zero blanking, decimal points and anti-ghost blanking.
//
//   state | meaning
//   ------+-------------------------------------------
//   DIG_0 | slot for digit 0 (least significant)
//   DIG_1 | slot for digit 1
//   DIG_2 | slot for digit 2
//   DIG_3 | slot for digit 3; its terminal count starts a new frame
module seg7_scan_4d
   import seg7_scan_4d_pkg::*;
#(
   parameter int PRESCALE  = PRESCALE_DEF,
   parameter int BLANK_CYC = BLANK_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [15:0] bcd,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = $clog2(PRESCALE);

   // Down-counter: PRE_LOAD corresponds to slot position 0, zero is the terminal count.
   localparam logic [CW-1:0] PRE_LOAD      = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] PRE_BLANK_LIM = CW'(PRESCALE - BLANK_CYC);

   logic [CW-1:0] pre_cnt;
   logic          tc;
   logic          frame_start;
   logic          in_blank;

   digit_idx_e    idx, idx_nxt;
   logic [1:0]    idx_b;

   logic [15:0]   snap_bcd;
   logic [3:0]    snap_dp;
   logic          snap_lz;

   logic          en_run;
   logic [3:0]    lz_blank;
   logic [3:0]    cur_digit;
   logic [6:0]    dec_seg;
   logic          an_on;
   logic [7:0]    an_d;
   logic          dp_d;

   assign tc          = (pre_cnt == '0);
   assign frame_start = tc && (idx == DIG_3);
   assign in_blank    = (BLANK_CYC > 0) && (pre_cnt >= PRE_BLANK_LIM);
   assign idx_b       = idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= PRE_LOAD;
      end else if (tc) begin
         pre_cnt <= PRE_LOAD;
      end else begin
         pre_cnt <= pre_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= DIG_0;
      end else begin
         idx <= idx_nxt;
      end
   end

   always_comb begin
      idx_nxt = idx;
      if (tc) begin
         case (idx)
            DIG_0:   idx_nxt = DIG_1;
            DIG_1:   idx_nxt = DIG_2;
            DIG_2:   idx_nxt = DIG_3;
            DIG_3:   idx_nxt = DIG_0;
            default: idx_nxt = DIG_0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_bcd <= '0;
         snap_dp  <= '0;
         snap_lz  <= 1'b0;
      end else if (frame_start) begin
         snap_bcd <= bcd;
         snap_dp  <= dp_mask;
         snap_lz  <= blank_lz;
      end
   end

   // Dropping en kills the display at once; re-enabling waits for a slot boundary
   // so a digit never lights for a partial slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_run <= 1'b1;
      end else if (!en) begin
         en_run <= 1'b0;
      end else if (tc) begin
         en_run <= 1'b1;
      end
   end

   always_comb begin
      lz_blank    = 4'b0000;
      lz_blank[3] = snap_lz && (snap_bcd[15:12] == 4'd0);
      lz_blank[2] = lz_blank[3] && (snap_bcd[11:8] == 4'd0);
      lz_blank[1] = lz_blank[2] && (snap_bcd[7:4] == 4'd0);
   end

   always_comb begin
      cur_digit = snap_bcd[3:0];
      case (idx)
         DIG_0:   cur_digit = snap_bcd[3:0];
         DIG_1:   cur_digit = snap_bcd[7:4];
         DIG_2:   cur_digit = snap_bcd[11:8];
         DIG_3:   cur_digit = snap_bcd[15:12];
         default: cur_digit = snap_bcd[3:0];
      endcase
   end

   seg7_decoder u_dec (
      .digit (cur_digit),
      .seg   (dec_seg)
   );

   // The decimal point follows the anode so it never shows on a dark digit.
   always_comb begin
      an_on = en && en_run && !in_blank && !lz_blank[idx_b];
      an_d  = an_on ? an_select(idx_b) : AN_OFF;
      dp_d  = !(an_on && snap_dp[idx_b]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_d;
         seg <= dec_seg;
         dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_4d.sv
// Directed bench for seg7_scan_4d with PRESCALE=4, BLANK_CYC=1 (16-clock frames).
// Expected anode/segment/dp values per cycle are written out by hand per frame.
module tb_seg7_scan_4d;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GD = 7'b0111111;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [15:0] bcd;
   logic [3:0]  dp_mask;
   logic        blank_lz;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] an_exp [4];

   always #5 clk = ~clk;

   seg7_scan_4d #(
      .PRESCALE  (4),
      .BLANK_CYC (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .bcd      (bcd),
      .dp_mask  (dp_mask),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cyc(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp);
      tick();
      chk({tag, "_an"}, an, e_an);
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, e_seg});
      chk({tag, "_dp"}, {7'b0, dp}, {7'b0, e_dp});
   endtask

   task automatic check_slot(input string tag, input int slot, input logic on,
                             input logic [6:0] g, input logic dp_req);
      logic [7:0] a;
      string      t;
      a = on ? an_exp[slot] : 8'hFF;
      t = $sformatf("%s_s%0d", tag, slot);
      check_cyc(t, 8'hFF, g, 1'b1);
      repeat (3) check_cyc(t, a, g, !(on && dp_req));
   endtask

   task automatic check_frame(input string tag, input logic [3:0] on,
                              input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3,
                              input logic [3:0] dpm);
      check_slot(tag, 0, on[0], g0, dpm[0]);
      check_slot(tag, 1, on[1], g1, dpm[1]);
      check_slot(tag, 2, on[2], g2, dpm[2]);
      check_slot(tag, 3, on[3], g3, dpm[3]);
   endtask

   initial begin
      an_exp[0] = 8'hFE;
      an_exp[1] = 8'hFD;
      an_exp[2] = 8'hFB;
      an_exp[3] = 8'hF7;

      reset    = 1'b1;
      en       = 1'b1;
      bcd      = 16'h0000;
      dp_mask  = 4'b0000;
      blank_lz = 1'b0;

      repeat (5) check_cyc("reset", 8'hFF, 7'h7F, 1'b1);

      // Inputs written before each frame check are captured at that frame's end.
      reset = 1'b0;
      bcd   = 16'h0325;
      check_frame("f0_zero", 4'b1111, G0, G0, G0, G0, 4'b0000);

      bcd      = 16'h0025;
      blank_lz = 1'b1;
      dp_mask  = 4'b1000;
      check_frame("f1_0325", 4'b1111, G5, G2, G3, G0, 4'b0000);

      bcd     = 16'h0000;
      dp_mask = 4'b0000;
      check_frame("f2_lz0025", 4'b0011, G5, G2, G0, G0, 4'b1000);

      bcd      = 16'h0325;
      blank_lz = 1'b0;
      check_frame("f3_lz0000", 4'b0001, G0, G0, G0, G0, 4'b0000);

      check_slot("f4_0325", 0, 1'b1, G5, 1'b0);
      check_cyc("f4_0325_s1", 8'hFF, G2, 1'b1);
      bcd = 16'h0999;
      repeat (3) check_cyc("f4_0325_s1", 8'hFD, G2, 1'b1);
      check_slot("f4_0325", 2, 1'b1, G3, 1'b0);
      check_slot("f4_0325", 3, 1'b1, G0, 1'b0);

      bcd     = 16'h00A0;
      dp_mask = 4'b0100;
      check_frame("f5_0999", 4'b1111, G9, G9, G9, G0, 4'b0000);

      bcd     = 16'h0325;
      dp_mask = 4'b0000;
      check_frame("f6_00a0", 4'b1111, G0, GD, G0, G0, 4'b0100);

      check_slot("f7_en", 0, 1'b1, G5, 1'b0);
      en = 1'b0;
      check_slot("f7_en", 1, 1'b0, G2, 1'b0);
      check_slot("f7_en", 2, 1'b0, G3, 1'b0);
      repeat (2) check_cyc("f7_en_s3", 8'hFF, G0, 1'b1);
      en = 1'b1;
      repeat (2) check_cyc("f7_en_s3_resume", 8'hFF, G0, 1'b1);

      check_frame("f8_0325", 4'b1111, G5, G2, G3, G0, 4'b0000);

      check_slot("f9_mid", 0, 1'b1, G5, 1'b0);
      check_cyc("f9_mid_s1", 8'hFF, G2, 1'b1);
      check_cyc("f9_mid_s1", 8'hFD, G2, 1'b1);
      reset = 1'b1;
      repeat (2) check_cyc("rst_mid", 8'hFF, 7'h7F, 1'b1);
      reset = 1'b0;
      check_frame("post_rst", 4'b1111, G0, G0, G0, G0, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
